// File: rtl/genius_seq_engine_if.sv
// Game-side bus of the sequence engine: control strobes in, display/status out.
//   master : start, tick, target, btn  -> engine
//   slave  : leds, round, points, user_turn, round_ok, win, lose -> display side
interface genius_seq_engine_if #(
    parameter int unsigned P_KEYS  = 4,
    parameter int unsigned P_DEPTH = 16
);
    localparam int unsigned RW = $clog2(P_DEPTH + 1);

    logic              start;
    logic              tick;
    logic [RW-1:0]     target;
    logic [P_KEYS-1:0] btn;
    logic [P_KEYS-1:0] leds;
    logic [RW-1:0]     round;
    logic [7:0]        points;
    logic              user_turn;
    logic              round_ok;
    logic              win;
    logic              lose;

    modport master (
        output start, tick, target, btn,
        input  leds, round, points, user_turn, round_ok, win, lose
    );

    modport slave (
        input  start, tick, target, btn,
        output leds, round, points, user_turn, round_ok, win, lose
    );
endinterface

// File: rtl/genius_seq_engine.sv
// Sequence-game engine: grows a pseudo-random symbol sequence one entry per
// round, plays it on the LEDs, then checks each press as it arrives.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   R        : synchronous active-high reset
//   bus      : slave side of genius_seq_engine_if (start/tick/target/btn in,
//              leds/round/points/user_turn/round_ok/win/lose out, all registered)
module genius_seq_engine #(
    parameter int unsigned P_KEYS    = 4,
    parameter int unsigned P_DEPTH   = 16,
    parameter int unsigned P_TIMEOUT = 5,
    parameter logic [7:0]  P_SEED    = 8'hA5
) (
    input logic                CLOCK_50,
    input logic                R,
    genius_seq_engine_if.slave bus
);
    localparam int unsigned KW = $clog2(P_KEYS);
    localparam int unsigned RW = $clog2(P_DEPTH + 1);
    localparam int unsigned IW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int unsigned TW = $clog2(P_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_WIN, S_LOSE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d, lfsr_step;
    logic [RW-1:0]     round_q, round_d;
    logic [RW-1:0]     tgt_q, tgt_d;
    logic [RW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [7:0]        points_q, points_d;
    logic [P_KEYS-1:0] leds_q, leds_d;
    logic              round_ok_q, round_ok_d;
    logic              user_turn_q, user_turn_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic              mem_we;
    logic [KW-1:0]     rd_sym;
    logic [P_KEYS-1:0] exp_key;
    logic              idx_last;
    logic [KW-1:0]     mem_q [P_DEPTH];

    // Fibonacci LFSR, taps 8,6,5,4
    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign exp_key   = P_KEYS'(1) << mem_q[IW'(idx_q)];
    assign idx_last  = (idx_q + RW'(1)) == round_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        round_d    = round_q;
        tgt_d      = tgt_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        points_d   = points_q;
        round_ok_d = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (state_q == S_IDLE) lfsr_d = lfsr_step;
                if (bus.start) begin
                    round_d  = '0;
                    points_d = '0;
                    if (bus.target == '0)                tgt_d = RW'(1);
                    else if (bus.target > RW'(P_DEPTH))  tgt_d = RW'(P_DEPTH);
                    else                                 tgt_d = bus.target;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                mem_we  = 1'b1;
                lfsr_d  = lfsr_step;
                round_d = round_q + RW'(1);
                idx_d   = '0;
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (bus.tick) state_d = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (bus.tick) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = S_INPUT;
                    end else begin
                        idx_d   = idx_q + RW'(1);
                        state_d = S_SHOW_ON;
                    end
                end
            end
            S_INPUT: begin
                // A press always wins over a coincident tick
                if (bus.btn != '0) begin
                    if (bus.btn == exp_key) begin
                        points_d = (points_q == 8'hFF) ? points_q : points_q + 8'd1;
                        timer_d  = '0;
                        idx_d    = idx_q + RW'(1);
                        if (idx_last) begin
                            round_ok_d = 1'b1;
                            state_d    = (round_q == tgt_q) ? S_WIN : S_ADD;
                        end
                    end else begin
                        state_d = S_LOSE;
                    end
                end else if (bus.tick) begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q + TW'(1) == TW'(P_TIMEOUT)) state_d = S_LOSE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Forward the symbol being written so round 1 lights without a bubble
        rd_sym = (mem_we && idx_d == round_q) ? lfsr_q[KW-1:0] : mem_q[IW'(idx_d)];

        unique case (state_d)
            S_SHOW_ON: leds_d = P_KEYS'(1) << rd_sym;
            S_INPUT:   leds_d = bus.btn;
            S_WIN:     leds_d = '1;
            default:   leds_d = '0;
        endcase
        user_turn_d = (state_d == S_INPUT);
        win_d       = (state_d == S_WIN);
        lose_d      = (state_d == S_LOSE);
    end

    // Control and output registers
    always_ff @(posedge CLOCK_50) begin
        if (R) begin
            state_q     <= S_IDLE;
            lfsr_q      <= P_SEED;
            round_q     <= '0;
            tgt_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            points_q    <= '0;
            leds_q      <= '0;
            round_ok_q  <= 1'b0;
            user_turn_q <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            round_q     <= round_d;
            tgt_q       <= tgt_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            points_q    <= points_d;
            leds_q      <= leds_d;
            round_ok_q  <= round_ok_d;
            user_turn_q <= user_turn_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
        end
    end

    // Symbol memory, contents need no reset
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) mem_q[IW'(round_q)] <= lfsr_q[KW-1:0];
    end

    assign bus.leds      = leds_q;
    assign bus.round     = round_q;
    assign bus.points    = points_q;
    assign bus.user_turn = user_turn_q;
    assign bus.round_ok  = round_ok_q;
    assign bus.win       = win_q;
    assign bus.lose      = lose_q;
endmodule

// File: tb/tb_genius_seq_engine.sv
// Directed bench for genius_seq_engine with default parameters
// (4 keys, depth 16, timeout 5, seed 8'hA5).
module tb_genius_seq_engine;
    localparam int unsigned KEYS  = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  SEED  = 8'hA5;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [7:0] m_lfsr;
    logic       m_idle;
    logic [1:0] m_seq[$];

    genius_seq_engine_if #(.P_KEYS(KEYS), .P_DEPTH(DEPTH)) bus_if ();

    genius_seq_engine #(
        .P_KEYS(KEYS), .P_DEPTH(DEPTH), .P_TIMEOUT(5), .P_SEED(SEED)
    ) u_dut (
        .CLOCK_50 (clk),
        .R        (rst),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the LFSR model free-runs while the engine idles
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_lfsr = SEED;
            m_idle = 1'b1;
        end else if (m_idle) begin
            m_lfsr = lfsr_next(m_lfsr);
        end
        #1;
    endtask

    task automatic start_game(input logic [4:0] t);
        bus_if.target = t;
        bus_if.start  = 1'b1;
        cyc();
        bus_if.start  = 1'b0;
        m_idle = 1'b0;
        m_seq  = {};
    endtask

    // Engine is in ADD: append the model symbol and step once
    task automatic do_add();
        m_seq.push_back(m_lfsr[1:0]);
        m_lfsr = lfsr_next(m_lfsr);
        cyc();
    endtask

    task automatic play_round();
        for (int i = 0; i < m_seq.size(); i++) begin
            check_eq("show_on", 32'(bus_if.leds), 32'(4'(1) << m_seq[i]));
            bus_if.tick = 1'b1; cyc(); bus_if.tick = 1'b0;
            check_eq("show_off", 32'(bus_if.leds), 32'h0);
            bus_if.tick = 1'b1; cyc(); bus_if.tick = 1'b0;
        end
        check_eq("user_turn", 32'(bus_if.user_turn), 32'h1);
    endtask

    task automatic press(input logic [1:0] k);
        bus_if.btn = 4'(1) << k;
        cyc();
        bus_if.btn = '0;
    endtask

    task automatic press_round();
        for (int i = 0; i < m_seq.size(); i++) begin
            press(m_seq[i]);
            check_eq("round_ok", 32'(bus_if.round_ok), (i == m_seq.size() - 1) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic idle_tick(input logic with_gap);
        bus_if.tick = 1'b1; cyc(); bus_if.tick = 1'b0;
        if (with_gap) cyc();
    endtask

    initial begin
        logic [1:0] wrong;
        n_tests = 0;
        n_fail  = 0;
        m_lfsr  = SEED;
        m_idle  = 1'b1;
        rst           = 1'b1;
        bus_if.start  = 1'b0;
        bus_if.tick   = 1'b0;
        bus_if.target = '0;
        bus_if.btn    = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check_eq("rst_leds",   32'(bus_if.leds),      32'h0);
        check_eq("rst_round",  32'(bus_if.round),     32'h0);
        check_eq("rst_points", 32'(bus_if.points),    32'h0);
        check_eq("rst_flags",  32'({bus_if.user_turn, bus_if.round_ok, bus_if.win, bus_if.lose}), 32'h0);

        // Target 2, all presses correct; start mid-INPUT must be ignored
        start_game(5'd2);
        do_add();
        check_eq("first_led", 32'(bus_if.leds), 32'(4'(1) << m_seq[0]));
        check_eq("round1", 32'(bus_if.round), 32'h1);
        play_round();
        press_round();
        check_eq("a_pts1", 32'(bus_if.points), 32'h1);
        do_add();
        check_eq("round2", 32'(bus_if.round), 32'h2);
        play_round();
        bus_if.start = 1'b1; cyc(); bus_if.start = 1'b0;
        check_eq("ign_start_turn",  32'(bus_if.user_turn), 32'h1);
        check_eq("ign_start_round", 32'(bus_if.round),     32'h2);
        press_round();
        check_eq("a_win",    32'(bus_if.win),    32'h1);
        check_eq("a_leds",   32'(bus_if.leds),   32'hF);
        check_eq("a_round",  32'(bus_if.round),  32'h2);
        check_eq("a_points", 32'(bus_if.points), 32'h3);
        cyc();
        check_eq("a_rok_pulse", 32'(bus_if.round_ok), 32'h0);
        check_eq("a_win_hold",  32'(bus_if.win),      32'h1);

        // Target 3, wrong key on second press of round 2
        start_game(5'd3);
        do_add(); play_round(); press_round();
        do_add(); play_round();
        press(m_seq[0]);
        wrong = m_seq[1] + 2'd1;
        press(wrong);
        check_eq("b_lose",   32'(bus_if.lose),      32'h1);
        check_eq("b_points", 32'(bus_if.points),    32'h2);
        check_eq("b_round",  32'(bus_if.round),     32'h2);
        check_eq("b_turn",   32'(bus_if.user_turn), 32'h0);
        check_eq("b_leds",   32'(bus_if.leds),      32'h0);

        // Two keys at once
        start_game(5'd5);
        do_add(); play_round();
        bus_if.btn = 4'b0011; cyc(); bus_if.btn = '0;
        check_eq("c_multi_lose", 32'(bus_if.lose),   32'h1);
        check_eq("c_points",     32'(bus_if.points), 32'h0);

        // Timeout: loss on the 5th tick in INPUT
        start_game(5'd2);
        do_add(); play_round();
        for (int k = 1; k <= 5; k++) begin
            idle_tick(1'b1);
            check_eq("d_timeout", 32'(bus_if.lose), (k == 5) ? 32'h1 : 32'h0);
        end

        // Press on the 4th tick clears the timer
        start_game(5'd2);
        do_add(); play_round(); press_round();
        do_add(); play_round();
        for (int k = 0; k < 3; k++) idle_tick(1'b0);
        bus_if.tick = 1'b1;
        bus_if.btn  = 4'(1) << m_seq[0];
        cyc();
        bus_if.tick = 1'b0;
        bus_if.btn  = '0;
        check_eq("e_pts",  32'(bus_if.points),    32'h2);
        check_eq("e_turn", 32'(bus_if.user_turn), 32'h1);
        for (int k = 0; k < 4; k++) begin
            idle_tick(1'b0);
            check_eq("e_no_lose", 32'(bus_if.lose), 32'h0);
        end
        press(m_seq[1]);
        check_eq("e_win", 32'(bus_if.win),    32'h1);
        check_eq("e_pts3", 32'(bus_if.points), 32'h3);

        // Target 0 clamps to 1
        start_game(5'd0);
        do_add(); play_round(); press_round();
        check_eq("clamp0_win",   32'(bus_if.win),   32'h1);
        check_eq("clamp0_round", 32'(bus_if.round), 32'h1);

        // Target 31 clamps to 16
        start_game(5'd31);
        for (int r = 1; r <= 16; r++) begin
            do_add(); play_round(); press_round();
            check_eq("clamp16_win", 32'(bus_if.win), (r == 16) ? 32'h1 : 32'h0);
        end
        check_eq("clamp16_round",  32'(bus_if.round),  32'd16);
        check_eq("clamp16_points", 32'(bus_if.points), 32'd136);

        // Reset during SHOW_ON, then reseeded game from IDLE
        start_game(5'd2);
        do_add();
        rst = 1'b1; cyc(); rst = 1'b0;
        check_eq("r_leds",  32'(bus_if.leds),      32'h0);
        check_eq("r_round", 32'(bus_if.round),     32'h0);
        check_eq("r_flags", 32'({bus_if.user_turn, bus_if.round_ok, bus_if.win, bus_if.lose}), 32'h0);
        cyc(); cyc(); cyc();
        start_game(5'd1);
        do_add();
        check_eq("r_first_led", 32'(bus_if.leds), 32'(4'(1) << m_seq[0]));
        play_round(); press_round();
        check_eq("r_win", 32'(bus_if.win), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
